// File: rtl/cpu27_pkg.sv
// Shared pipeline encodings for the ID-stage hazard unit.
// Availability stages and forward-select codes share numbering so one maps directly onto the other.
package cpu27_pkg;

    localparam logic [1:0] AVAIL_NONE = 2'd0;
    localparam logic [1:0] AVAIL_EXE  = 2'd1;
    localparam logic [1:0] AVAIL_MEM  = 2'd2;
    localparam logic [1:0] AVAIL_WB   = 2'd3;

    localparam logic [1:0] FWD_RF     = 2'd0;
    localparam logic [1:0] FWD_EXE    = 2'd1;
    localparam logic [1:0] FWD_MEM    = 2'd2;
    localparam logic [1:0] FWD_WB     = 2'd3;

    // Bypass source for a producer that currently sits in the given stage.
    function automatic logic [1:0] stage_fwd(input logic [1:0] stage);
        case (stage)
            AVAIL_EXE: return FWD_EXE;
            AVAIL_MEM: return FWD_MEM;
            AVAIL_WB:  return FWD_WB;
            default:   return FWD_RF;
        endcase
    endfunction

endpackage

// File: rtl/id_scoreboard_if.sv
// ID-stage <-> hazard unit bundle: decode operands, pipeline handshakes, issue verdict.
interface id_scoreboard_if #(
    parameter int unsigned AW  = 5,
    parameter int unsigned NRD = 2
);
    logic              id_go;
    logic [AW-1:0]     id_wnum;
    logic [1:0]        id_avail;
    logic [NRD-1:0]    id_rd_en;
    logic [NRD*AW-1:0] id_rd_num;
    logic              id_rd_hilo;
    logic              id_mdu_start;
    logic              exe_go;
    logic              mem_go;
    logic              wb_go;
    logic              flush;
    logic              ready;
    logic [NRD*2-1:0]  fwd_sel;
    logic              mdu_busy;

    modport master (
        output id_go, id_wnum, id_avail, id_rd_en, id_rd_num, id_rd_hilo,
               id_mdu_start, exe_go, mem_go, wb_go, flush,
        input  ready, fwd_sel, mdu_busy
    );

    modport slave (
        input  id_go, id_wnum, id_avail, id_rd_en, id_rd_num, id_rd_hilo,
               id_mdu_start, exe_go, mem_go, wb_go, flush,
        output ready, fwd_sel, mdu_busy
    );
endinterface

// File: rtl/id_fwd_match.sv
// One decode read port against the EXE/MEM/WB writer tags: pick the youngest
// matching producer, bypass from it if its result already exists, else stall.
module id_fwd_match
    import cpu27_pkg::*;
#(
    parameter int unsigned AW = 5
) (
    input  logic          i_exe_v,
    input  logic [AW-1:0] i_exe_wnum,
    input  logic [1:0]    i_exe_avail,
    input  logic          i_mem_v,
    input  logic [AW-1:0] i_mem_wnum,
    input  logic [1:0]    i_mem_avail,
    input  logic          i_wb_v,
    input  logic [AW-1:0] i_wb_wnum,
    input  logic [1:0]    i_wb_avail,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_num,
    output logic [1:0]    o_fwd_sel_c,
    output logic          o_stall_c
);

    logic       w_rd_live;
    logic [1:0] w_hit_stage;
    logic [1:0] w_hit_avail;

    assign w_rd_live = i_rd_en && (i_rd_num != '0);

    // Priority EXE > MEM > WB: the youngest writer holds the architecturally newest value.
    always_comb begin
        w_hit_stage = AVAIL_NONE;
        w_hit_avail = AVAIL_NONE;
        if (w_rd_live && i_exe_v && (i_exe_wnum == i_rd_num)) begin
            w_hit_stage = AVAIL_EXE;
            w_hit_avail = i_exe_avail;
        end else if (w_rd_live && i_mem_v && (i_mem_wnum == i_rd_num)) begin
            w_hit_stage = AVAIL_MEM;
            w_hit_avail = i_mem_avail;
        end else if (w_rd_live && i_wb_v && (i_wb_wnum == i_rd_num)) begin
            w_hit_stage = AVAIL_WB;
            w_hit_avail = i_wb_avail;
        end
    end

    always_comb begin
        o_fwd_sel_c = FWD_RF;
        o_stall_c   = 1'b0;
        if (w_hit_stage != AVAIL_NONE) begin
            if (w_hit_avail <= w_hit_stage) begin
                o_fwd_sel_c = stage_fwd(w_hit_stage);
            end else begin
                o_stall_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// Decode-stage hazard unit: shadow pipeline of writer tags plus MDU busy interlock.
// ready/fwd_sel depend only on registered state and ID operands, never on the *_go handshakes.
module id_scoreboard
    import cpu27_pkg::*;
#(
    parameter int unsigned AW      = 5,
    parameter int unsigned NRD     = 2,
    parameter int unsigned MDU_LAT = 8
) (
    input  logic          clk,
    input  logic          resetn,
    id_scoreboard_if.slave sb
);

    localparam int unsigned CW = $clog2(MDU_LAT + 1);

    typedef struct packed {
        logic          v;
        logic [AW-1:0] wnum;
        logic [1:0]    avail;
    } tag_t;

    tag_t           r_exe;
    tag_t           r_mem;
    tag_t           r_wb;
    logic [CW-1:0]  r_cnt;
    tag_t           w_id_tag;
    logic [NRD-1:0] w_stall;
    logic           w_mdu_busy;

    // Instructions with no result or targeting r0 never create a hazard.
    assign w_id_tag = {(sb.id_avail != AVAIL_NONE) && (sb.id_wnum != '0),
                       sb.id_wnum, sb.id_avail};

    // Each slot: flush > load from upstream > bubble on own advance > hold.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_exe <= '0;
            r_mem <= '0;
            r_wb  <= '0;
        end else begin
            if (sb.flush)       r_exe.v <= 1'b0;
            else if (sb.id_go)  r_exe   <= w_id_tag;
            else if (sb.exe_go) r_exe.v <= 1'b0;

            if (sb.flush)       r_mem.v <= 1'b0;
            else if (sb.exe_go) r_mem   <= r_exe;
            else if (sb.mem_go) r_mem.v <= 1'b0;

            if (sb.flush)       r_wb.v  <= 1'b0;
            else if (sb.mem_go) r_wb    <= r_mem;
            else if (sb.wb_go)  r_wb.v  <= 1'b0;
        end
    end

    // MDU latency countdown; flush abandons an in-flight mul/div even on a new start.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else if (sb.flush) begin
            r_cnt <= '0;
        end else if (sb.id_go && sb.id_mdu_start) begin
            r_cnt <= CW'(MDU_LAT);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end

    assign w_mdu_busy  = (r_cnt != '0);
    assign sb.mdu_busy = w_mdu_busy;

    for (genvar k = 0; k < NRD; k++) begin : g_port
        id_fwd_match #(.AW(AW)) u_match (
            .i_exe_v     (r_exe.v),
            .i_exe_wnum  (r_exe.wnum),
            .i_exe_avail (r_exe.avail),
            .i_mem_v     (r_mem.v),
            .i_mem_wnum  (r_mem.wnum),
            .i_mem_avail (r_mem.avail),
            .i_wb_v      (r_wb.v),
            .i_wb_wnum   (r_wb.wnum),
            .i_wb_avail  (r_wb.avail),
            .i_rd_en     (sb.id_rd_en[k]),
            .i_rd_num    (sb.id_rd_num[k*AW +: AW]),
            .o_fwd_sel_c (sb.fwd_sel[k*2 +: 2]),
            .o_stall_c   (w_stall[k])
        );
    end

    assign sb.ready = !(|w_stall) && !((sb.id_rd_hilo || sb.id_mdu_start) && w_mdu_busy);

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed bench for id_scoreboard: stimulus queues expected {ready,fwd_sel,mdu_busy},
// an independent monitor compares them against the DUT on the falling edge.
module tb_id_scoreboard;

    localparam int unsigned AW  = 5;
    localparam int unsigned NRD = 2;

    logic clk;
    logic resetn;
    logic chk;
    logic done;

    logic [5:0] exp_q[$];
    string      name_q[$];

    id_scoreboard_if #(.AW(AW), .NRD(NRD)) sb();

    id_scoreboard #(.AW(AW), .NRD(NRD), .MDU_LAT(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .sb     (sb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: owns the counters and the summary line.
    initial begin : monitor
        int n_checks;
        int n_fail;
        logic [5:0] exp;
        logic [5:0] act;
        string nm;
        n_checks = 0;
        n_fail   = 0;
        forever begin
            @(negedge clk);
            if (chk) begin
                n_checks++;
                act = {sb.ready, sb.fwd_sel, sb.mdu_busy};
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL no_expectation: got ready/fwd/busy %b/%b/%b",
                             act[5], act[4:1], act[0]);
                end else begin
                    exp = exp_q.pop_front();
                    nm  = name_q.pop_front();
                    if (act !== exp) begin
                        n_fail++;
                        $display("FAIL %s: ready/fwd/busy got %b/%b/%b want %b/%b/%b",
                                 nm, act[5], act[4:1], act[0], exp[5], exp[4:1], exp[0]);
                    end
                end
            end
            if (done) begin
                n_checks++;
                if (exp_q.size() != 0) begin
                    n_fail++;
                    $display("FAIL leftover: got %0d pending expectations want 0", exp_q.size());
                end
                $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
                $finish;
            end
        end
    end

    task automatic cyc(input string name, input bit do_chk, input bit e_rdy,
                       input logic [3:0] e_fwd, input bit e_busy);
        if (do_chk) begin
            exp_q.push_back({e_rdy, e_fwd, e_busy});
            name_q.push_back(name);
            chk = 1'b1;
        end
        @(negedge clk);
        #1 chk = 1'b0;
        @(posedge clk);
        #1;
        sb.id_go        = 1'b0;
        sb.id_mdu_start = 1'b0;
        sb.exe_go       = 1'b0;
        sb.mem_go       = 1'b0;
        sb.wb_go        = 1'b0;
        sb.flush        = 1'b0;
    endtask

    task automatic step();
        cyc("", 1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    task automatic check(input string name, input bit e_rdy, input logic [3:0] e_fwd, input bit e_busy);
        cyc(name, 1'b1, e_rdy, e_fwd, e_busy);
    endtask

    task automatic rd(input logic [1:0] en, input logic [AW-1:0] n0, input logic [AW-1:0] n1);
        sb.id_rd_en  = en;
        sb.id_rd_num = {n1, n0};
    endtask

    task automatic issue(input logic [AW-1:0] w, input logic [1:0] a);
        sb.id_go    = 1'b1;
        sb.id_wnum  = w;
        sb.id_avail = a;
    endtask

    initial begin : stim
        chk = 1'b0; done = 1'b0; resetn = 1'b0;
        sb.id_go = 1'b0; sb.id_wnum = '0; sb.id_avail = 2'd0;
        sb.id_rd_en = '0; sb.id_rd_num = '0; sb.id_rd_hilo = 1'b0;
        sb.id_mdu_start = 1'b0; sb.exe_go = 1'b0; sb.mem_go = 1'b0;
        sb.wb_go = 1'b0; sb.flush = 1'b0;
        @(posedge clk); #1;

        rd(2'b11, 5'd5, 5'd7);
        check("reset_hold", 1'b1, 4'b0000, 1'b0);
        resetn = 1'b1;
        check("reset_idle", 1'b1, 4'b0000, 1'b0);

        // ALU result marches EXE -> MEM -> WB -> retired
        rd(2'b00, 5'd0, 5'd0); issue(5'd5, 2'd1); step();
        rd(2'b01, 5'd5, 5'd0); sb.exe_go = 1'b1;
        check("alu_exe", 1'b1, 4'b0001, 1'b0);
        sb.mem_go = 1'b1; check("alu_mem", 1'b1, 4'b0010, 1'b0);
        sb.wb_go = 1'b1;  check("alu_wb", 1'b1, 4'b0011, 1'b0);
        check("alu_retired", 1'b1, 4'b0000, 1'b0);

        // Load-use on port 1
        rd(2'b00, 5'd0, 5'd0); issue(5'd7, 2'd2); step();
        rd(2'b10, 5'd0, 5'd7); sb.exe_go = 1'b1;
        check("ldu_exe", 1'b0, 4'b0000, 1'b0);
        sb.mem_go = 1'b1; check("ldu_mem", 1'b1, 4'b1000, 1'b0);
        sb.wb_go = 1'b1;  check("ldu_wb", 1'b1, 4'b1100, 1'b0);

        // Result only available in WB
        rd(2'b00, 5'd0, 5'd0); issue(5'd9, 2'd3); step();
        rd(2'b01, 5'd9, 5'd0); sb.exe_go = 1'b1;
        check("wbres_exe", 1'b0, 4'b0000, 1'b0);
        sb.mem_go = 1'b1; check("wbres_mem", 1'b0, 4'b0000, 1'b0);
        sb.wb_go = 1'b1;  check("wbres_wb", 1'b1, 4'b0011, 1'b0);

        // Youngest match wins; disabled port ignored; flush clears all three slots
        rd(2'b00, 5'd0, 5'd0); issue(5'd3, 2'd1); step();
        issue(5'd3, 2'd1); sb.exe_go = 1'b1; step();
        rd(2'b01, 5'd3, 5'd3); issue(5'd3, 2'd2); sb.exe_go = 1'b1; sb.mem_go = 1'b1;
        check("young_alu", 1'b1, 4'b0001, 1'b0);
        sb.flush = 1'b1;
        check("young_stall", 1'b0, 4'b0000, 1'b0);
        check("flush_clear", 1'b1, 4'b0000, 1'b0);

        // r0 and no-result writers are never tracked
        rd(2'b00, 5'd0, 5'd0); issue(5'd0, 2'd1); step();
        rd(2'b11, 5'd0, 5'd0);
        check("r0_read", 1'b1, 4'b0000, 1'b0);
        rd(2'b00, 5'd0, 5'd0); issue(5'd4, 2'd0); step();
        rd(2'b10, 5'd0, 5'd4);
        check("avail_none", 1'b1, 4'b0000, 1'b0);

        // MDU latency interlock
        rd(2'b00, 5'd0, 5'd0); issue(5'd0, 2'd0); sb.id_mdu_start = 1'b1;
        check("mdu_accept", 1'b1, 4'b0000, 1'b0);
        sb.id_rd_hilo = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("mdu_wait%0d", i), 1'b0, 4'b0000, 1'b1);
        end
        check("mdu_done", 1'b1, 4'b0000, 1'b0);

        sb.id_rd_hilo = 1'b0; issue(5'd0, 2'd0); sb.id_mdu_start = 1'b1;
        check("mdu_restart", 1'b1, 4'b0000, 1'b0);
        sb.id_mdu_start = 1'b1;
        check("mdu_start_busy", 1'b0, 4'b0000, 1'b1);
        sb.id_rd_hilo = 1'b1;
        check("mdu_cyc2", 1'b0, 4'b0000, 1'b1);
        sb.flush = 1'b1;
        check("mdu_flush_cyc", 1'b0, 4'b0000, 1'b1);
        check("mdu_flushed", 1'b1, 4'b0000, 1'b0);

        sb.id_rd_hilo = 1'b0; issue(5'd0, 2'd0); sb.id_mdu_start = 1'b1; sb.flush = 1'b1;
        check("flush_vs_start", 1'b1, 4'b0000, 1'b0);
        check("flush_beat_load", 1'b1, 4'b0000, 1'b0);

        // Mid-run reset with three valid slots and a busy MDU
        rd(2'b00, 5'd0, 5'd0); issue(5'd10, 2'd1); step();
        issue(5'd11, 2'd1); sb.exe_go = 1'b1; step();
        issue(5'd12, 2'd1); sb.exe_go = 1'b1; sb.mem_go = 1'b1; sb.id_mdu_start = 1'b1; step();
        rd(2'b11, 5'd12, 5'd10);
        check("pre_reset", 1'b1, 4'b1101, 1'b1);
        resetn = 1'b0;
        check("reset_mid", 1'b1, 4'b0000, 1'b0);
        resetn = 1'b1;
        check("reset_after", 1'b1, 4'b0000, 1'b0);

        done = 1'b1;
    end

endmodule
